// File: rtl/ram_fifo_pkg.sv
// Shared constants and FSM state encoding for the RAM-backed FIFO controller.
package ram_fifo_pkg;

  localparam int FIFO_DW    = 32;
  localparam int FIFO_AW    = 5;
  localparam int FIFO_DEPTH = 32;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } fifo_state_e;

endpackage

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller that sequences an external single-port RAM, one access per cycle.
// Optional macro RAM_FIFO_INIT_CLEAR_EN adds an INIT pass that zeroes every RAM word after reset.
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
#(
  parameter int DW = FIFO_DW,
  parameter int AW = FIFO_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          ram_ena,
  output logic          ram_wena,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output fifo_state_e   state_dbg
);

  localparam logic [AW:0]   DEPTH_CNT = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   CNT_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};

`ifdef RAM_FIFO_INIT_CLEAR_EN
  localparam fifo_state_e RESET_STATE = INIT;
`else
  localparam fifo_state_e RESET_STATE = RUN;
`endif

  // Both ports use valid/ready: a word moves on a cycle where valid and ready are
  // both high at the rising edge; valid never depends on ready on the same side.

  fifo_state_e   state, state_next;
  logic [AW-1:0] wptr, rptr;
  logic          do_read, do_write;

`ifdef RAM_FIFO_INIT_CLEAR_EN
  logic [AW-1:0] init_cnt;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= RESET_STATE;
    else        state <= state_next;
  end

  // A pending pop refill wins the single RAM port; pushes wait for a free cycle.
  always_comb begin
    state_next = state;
    do_read    = 1'b0;
    do_write   = 1'b0;
    wr_ready   = 1'b0;
    ram_ena    = 1'b0;
    ram_wena   = 1'b0;
    ram_addr   = '0;
    ram_din    = '0;
    if (rst_n) begin
      case (state)
`ifdef RAM_FIFO_INIT_CLEAR_EN
        INIT: begin
          ram_ena  = 1'b1;
          ram_wena = 1'b1;
          ram_addr = init_cnt;
          if (init_cnt == {AW{1'b1}}) state_next = RUN;
        end
`endif
        RUN: begin
          do_read  = (count != '0) && (!rd_valid || rd_ready);
          wr_ready = (count != DEPTH_CNT) && !do_read;
          do_write = wr_valid && wr_ready;
          if (do_read) begin
            ram_ena  = 1'b1;
            ram_addr = rptr;
          end else if (do_write) begin
            ram_ena  = 1'b1;
            ram_wena = 1'b1;
            ram_addr = wptr;
            ram_din  = wr_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (do_write) begin
        wptr  <= wptr + PTR_ONE;
        count <= count + CNT_ONE;
      end else if (do_read) begin
        count <= count - CNT_ONE;
      end
      if (do_read) begin
        rptr     <= rptr + PTR_ONE;
        rd_data  <= ram_dout;
        rd_valid <= 1'b1;
      end else if (rd_ready && rd_valid) begin
        rd_valid <= 1'b0;
      end
    end
  end

`ifdef RAM_FIFO_INIT_CLEAR_EN
  always_ff @(posedge clk) begin
    if (!rst_n)             init_cnt <= '0;
    else if (state == INIT) init_cnt <= init_cnt + PTR_ONE;
  end
`endif

  assign full      = (count == DEPTH_CNT);
  assign empty     = (count == '0) && !rd_valid;
  assign state_dbg = state;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural single-port RAM and an expected-data queue.
module tb_ram_fifo_ctrl;
  import ram_fifo_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          ram_ena;
  logic          ram_wena;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  fifo_state_e   state_dbg;

  logic [DW-1:0] mem [32];
  logic [DW-1:0] exp_q [$];
  int n_tests = 0;
  int n_fail  = 0;

  // clock / reset
  always #5 clk = ~clk;

  ram_fifo_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .count(count), .full(full), .empty(empty),
    .ram_ena(ram_ena), .ram_wena(ram_wena), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout), .state_dbg(state_dbg)
  );

  always @(posedge clk) if (ram_ena && ram_wena) mem[ram_addr] <= ram_din;
  assign ram_dout = (ram_ena && !ram_wena) ? mem[ram_addr] : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard bookkeeping on the handshakes of this cycle, then advance one clock
  task automatic tick();
    #1;
    if (rst_n) begin
      if (wr_valid && wr_ready) exp_q.push_back(wr_data);
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) check("pop_unexpected", 1, 0);
        else                   check("pop_data", rd_data, exp_q.pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    bit done = 0;
    wr_valid = 1'b1;
    wr_data  = d;
    for (int k = 0; k < 20 && !done; k++) begin
      #1;
      done = wr_ready;
      tick();
    end
    if (!done) check("push_timeout", 0, 1);
    wr_valid = 1'b0;
  endtask

`ifdef RAM_FIFO_INIT_CLEAR_EN
  task automatic init_walk(input int stop_at);
    wr_valid = 1'b1;
    wr_data  = 32'h1234_5678;
    for (int i = 0; i < 32; i++) begin
      #1;
      check("init_ena", ram_ena, 1);
      check("init_wena", ram_wena, 1);
      check("init_addr", ram_addr, i);
      check("init_din", ram_din, 0);
      check("init_wr_ready", wr_ready, 0);
      check("init_rd_valid", rd_valid, 0);
      if (i == stop_at) begin
        rst_n = 1'b0;
        #1;
        check("init_rst_ena", ram_ena, 0);
        tick();
        tick();
        rst_n = 1'b1;
        wr_valid = 1'b0;
        return;
      end
      tick();
    end
    wr_valid = 1'b0;
    #1;
    check("init_done_state", state_dbg, RUN);
    check("init_done_wr_ready", wr_ready, 1);
    check("init_done_count", count, 0);
  endtask
`endif

  task automatic do_reset();
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    exp_q.delete();
`ifdef RAM_FIFO_INIT_CLEAR_EN
    init_walk(99);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset with a push attempt held: no RAM activity, no ready
    rst_n    = 1'b0;
    wr_valid = 1'b1;
    wr_data  = 32'hAAAA_5555;
    rd_ready = 1'b0;
    @(posedge clk);
    #1;
    tick();
    check("rst_wr_ready", wr_ready, 0);
    check("rst_ram_ena", ram_ena, 0);
    check("rst_ram_wena", ram_wena, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_din", ram_din, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_count", count, 0);
    wr_valid = 1'b0;
    rst_n    = 1'b1;
`ifdef RAM_FIFO_INIT_CLEAR_EN
    init_walk(17);
    init_walk(99);
`endif
    #1;
    check("rel_wr_ready", wr_ready, 1);
    check("rel_empty", empty, 1);
    check("rel_count", count, 0);
    check("rel_ram_ena", ram_ena, 0);
    check("rel_state", state_dbg, RUN);

    // single word: push at N, visible at N+2
    wr_valid = 1'b1;
    wr_data  = 32'hFFFF_FFFF;
    #1;
    check("sw_push_wena", ram_wena, 1);
    check("sw_push_addr", ram_addr, 0);
    check("sw_push_din", ram_din, 32'hFFFF_FFFF);
    tick();
    wr_valid = 1'b0;
    #1;
    check("sw_n1_rd_valid", rd_valid, 0);
    check("sw_n1_ram_ena", ram_ena, 1);
    check("sw_n1_ram_wena", ram_wena, 0);
    check("sw_n1_wr_ready", wr_ready, 0);
    check("sw_n1_count", count, 1);
    tick();
    check("sw_n2_rd_valid", rd_valid, 1);
    check("sw_n2_rd_data", rd_data, 32'hFFFF_FFFF);
    check("sw_n2_count", count, 0);
    check("sw_n2_ram_ena", ram_ena, 0);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    #1;
    check("sw_after_rd_valid", rd_valid, 0);
    check("sw_after_empty", empty, 1);

    // fill: 33 words counting down from all-ones
    for (int i = 0; i < 33; i++) push_word(32'hFFFF_FFFF - i);
    #1;
    check("fill_count", count, 32);
    check("fill_full", full, 1);
    check("fill_rd_valid", rd_valid, 1);
    wr_valid = 1'b1;
    wr_data  = 32'hFFFF_FFDE;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("fill_stall_wr_ready", wr_ready, 0);
      check("fill_stall_ram_ena", ram_ena, 0);
      tick();
    end
    wr_valid = 1'b0;
    check("fill_stall_count", count, 32);

    // drain: one pop per cycle, read address walks 2..31 then wraps through 0,1
    rd_ready = 1'b1;
    for (int i = 0; i < 33; i++) begin
      #1;
      check("drain_rd_valid", rd_valid, 1);
      if (i < 32) begin
        check("drain_ram_ena", ram_ena, 1);
        check("drain_ram_addr", ram_addr, (2 + i) % 32);
      end else begin
        check("drain_idle_ram_ena", ram_ena, 0);
      end
      tick();
    end
    check("drain_rd_valid_end", rd_valid, 0);
    check("drain_empty", empty, 1);
    check("drain_count", count, 0);
    check("drain_q_left", exp_q.size(), 0);
    rd_ready = 1'b0;

    // contention: a read owns the port, the push lands on the next read-free cycle
    for (int i = 0; i < 6; i++) push_word(32'h1000_0000 + i);
    #1;
    check("cont_count", count, 5);
    check("cont_rd_valid", rd_valid, 1);
    rd_ready = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 32'hCAFE_0001;
    #1;
    check("cont_wr_ready", wr_ready, 0);
    check("cont_ram_wena", ram_wena, 0);
    check("cont_ram_ena", ram_ena, 1);
    tick();
    check("cont2_wr_ready", wr_ready, 0);
    tick();
    rd_ready = 1'b0;
    #1;
    check("cont3_wr_ready", wr_ready, 1);
    check("cont3_ram_wena", ram_wena, 1);
    check("cont3_ram_din", ram_din, 32'hCAFE_0001);
    tick();
    wr_valid = 1'b0;
    check("cont_after_count", count, 4);
    rd_ready = 1'b1;
    for (int i = 0; i < 12 && !empty; i++) tick();
    check("cont_empty", empty, 1);
    check("cont_q_left", exp_q.size(), 0);
    rd_ready = 1'b0;

    // mid-stream reset discards contents and the in-flight push
    for (int i = 0; i < 3; i++) push_word(32'h5A5A_0000 + i);
    wr_valid = 1'b1;
    wr_data  = 32'h7777_7777;
    do_reset();
    #1;
    check("mrst_count", count, 0);
    check("mrst_rd_valid", rd_valid, 0);
    check("mrst_rd_data", rd_data, 0);
    check("mrst_empty", empty, 1);
    push_word(32'h0BAD_F00D);
    tick();
    check("mrst_new_rd_data", rd_data, 32'h0BAD_F00D);
    check("mrst_new_rd_valid", rd_valid, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 Parameter DW, default 32, data width; must equal the RAM word width.
REQ-002 Parameter AW, default 5, RAM address width; depth is 2**AW = 32 words.
REQ-003 clk  in  1  single clock, all logic on the rising edge.
REQ-004 rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 wr_valid  in  1  producer offers wr_data.
REQ-006 wr_ready  out  1  controller accepts wr_data this cycle.
REQ-007 wr_data  in  DW  push data.
REQ-008 rd_valid  out  1  rd_data holds the oldest word.
REQ-009 rd_ready  in  1  consumer takes rd_data this cycle.
REQ-010 rd_data  out  DW  registered pop data.
REQ-011 count  out  AW+1  words held in the RAM, 0..32; excludes the output register.
REQ-012 full / empty  out  1 each  full = (count==32); empty = (count==0) and !rd_valid.
REQ-013 ram_ena, ram_wena  out  1 each  RAM enable and write enable.
REQ-014 ram_addr  out  AW  RAM address.
REQ-015 ram_din  out  DW  RAM write data.
REQ-016 ram_dout  in  DW  RAM read data; combinational from ram_addr when ram_ena=1 and ram_wena=0.

Function
REQ-017 The block SHALL sequence a single-port 32x32 RAM as a FIFO, with one RAM access per cycle at most.
REQ-018 FSM states SHALL be INIT and RUN; INIT exists only per REQ-031, and RUN is terminal.
REQ-019 In RUN, do_read SHALL be asserted when count!=0 and (!rd_valid or rd_ready).
REQ-020 wr_ready SHALL be asserted in RUN when count!=32 and do_read=0; reads have priority (combinational path rd_ready->wr_ready is intended); do_write = wr_valid & wr_ready.
REQ-021 The RAM port SHALL be driven as follows:
- do_write: ram_ena=1, ram_wena=1, ram_addr=wptr, ram_din=wr_data.
- do_read: ram_ena=1, ram_wena=0, ram_addr=rptr.
- otherwise: ram_ena=0, ram_wena=0, ram_addr and ram_din hold 0.
REQ-022 On a do_read edge, rd_data SHALL load ram_dout and rd_valid SHALL set to 1; otherwise rd_ready & rd_valid SHALL clear rd_valid, and rd_data SHALL hold its value.
REQ-023 wptr/rptr SHALL increment mod 32 on do_write/do_read; address 31 wraps to 0.
REQ-024 count SHALL change by +1 on do_write, by -1 on do_read, and never change on both (the two are mutually exclusive).
REQ-025 Latency: a word pushed in cycle N on an empty FIFO SHALL appear as rd_valid=1 in cycle N+2; with rd_ready held high, throughput SHALL be one pop per cycle while count>0.
REQ-026 When full, wr_ready=0 and the push is stalled, never dropped. When count=0, no RAM read occurs and rd_valid falls after the last word is consumed.
REQ-027 Data order SHALL be strict FIFO; no word is duplicated or lost across wrap-around.

Reset
REQ-028 On a clk edge with rst_n=0, the block SHALL set wptr=0, rptr=0, count=0, rd_valid=0, rd_data=0, and the FSM to INIT (or RUN if REQ-031 is compiled out).
REQ-029 While rst_n=0, the outputs SHALL be wr_ready=0, ram_ena=0, ram_wena=0, ram_addr=0, ram_din=0.
REQ-030 A reset asserted mid-stream SHALL discard all contents; RAM data is not trusted afterwards, and an in-flight handshake in the reset cycle has no effect.

Configuration
REQ-031 Macro RAM_FIFO_INIT_CLEAR_EN:
- Defined: INIT writes 0 to addresses 0..31, one per cycle (ram_ena=1, ram_wena=1, ram_din=0, ram_addr=init counter), with wr_ready=0 and rd_valid=0; after address 31 the FSM enters RUN, 32 cycles after reset release.
- Undefined: the INIT state, init counter and logic are absent, and RUN is entered on the first edge after reset.

Structure
REQ-032 Package ram_fifo_pkg SHALL hold FIFO_DW=32, FIFO_AW=5, FIFO_DEPTH=32 and the state encoding (INIT=1'b0, RUN=1'b1).
REQ-033 No sub-module SHALL be used; the RAM is instantiated beside this block by the integrator, not inside it.

Verification
REQ-034 The bench SHALL cover the following scenarios:
- Reset, macro off: after rst_n=1, in the first cycle wr_ready=1, empty=1, count=0, ram_ena=0.
- Single word: push 32'hFFFF_FFFF at cycle N, rd_ready=0 -> rd_valid=1 at N+2, rd_data=32'hFFFF_FFFF, count=0.
- Fill: push 33 words 32'hFFFF_FFFF downward (decrement by 1) with rd_ready=0 -> 32 in RAM plus 1 in the output register, count=32, full=1, wr_ready=0; word 34 stalls.
- Drain with wrap: rd_ready=1 -> 33 words pop in order 32'hFFFF_FFFF..32'hFFFF_FFDF, one per cycle after the first; the pointers wrap to 0; empty=1 at the end.
- Contention: count=5, rd_valid=1, rd_ready=1, wr_valid=1 -> the cycle performs a read, wr_ready=0; the push completes in the next cycle that has no read.
- Macro on: after reset release, ram_wena=1 with addresses 0..31 and ram_din=0 for 32 cycles, wr_ready=0 throughout; a reset asserted at init address 17 restarts init from 0.
